fc_stream_driver: RTL and testbench
===================================

Name: fc_stream_driver

Overview:
- Initiator/collector at the far end of the FC accelerator's streaming interface.
- Host preloads an N-word x vector, then pulses start. The block streams x into the accelerator's input port using the valid/ready handshake.
- It then accepts M result words from the accelerator's output port, buffers them for host readback, and pulses done.
- Sits between a host/testbench and any generated fc_M_N_* core.

Parameters:
- WIDTH, 16, data word width (signed).
- N, 4, x vector length (words streamed out).
- M, 8, result count (words collected).
- LOGN, $clog2(N), x buffer address width (localparam).
- LOGM, $clog2(M), result buffer address width (localparam).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe into x buffer.
- wr_addr  in  LOGN  x buffer write address.
- wr_data  in  WIDTH  x word to write.
- start  in  1  single-cycle request to run one vector.
- busy  out  1  high from the accepted start until done is asserted.
- done  out  1  one-cycle pulse once the M-th result is stored.
- drv_valid  out  1  to the accelerator's input_valid.
- drv_ready  in  1  from the accelerator's input_ready.
- drv_data  out  WIDTH  to the accelerator's input_data.
- res_valid  in  1  from the accelerator's output_valid.
- res_ready  out  1  to the accelerator's output_ready.
- res_data  in  WIDTH  from the accelerator's output_data.
- rd_addr  in  LOGM  host result read address.
- rd_data  out  WIDTH  result word, registered, 1-cycle read latency.

Behaviour:
- Reset: async assert on reset_n low, synchronous deassert.
  - busy, done, drv_valid, res_ready, drv_data and rd_data all reset to 0.
  - State returns to IDLE and both counters reset to 0.
  - Buffer contents are not reset.
- FSM states: IDLE, SEND, RECV, DONE.
  - IDLE: start=1 goes to SEND and clears both counters. drv_valid rises the next cycle with drv_data=x[0].
  - SEND: drv_valid=1 and drv_data=x[snd_cnt]. A beat occurs when drv_valid&&drv_ready; it advances snd_cnt.
    - drv_data must stay stable while drv_ready=0.
    - On beat N-1, the next state is RECV and drv_valid drops the following cycle. There are no gaps between beats when drv_ready stays high.
  - RECV: res_ready=1. A beat occurs when res_valid&&res_ready; it writes res_data to rbuf[rcv_cnt] and advances rcv_cnt.
    - On beat M-1, the next state is DONE.
  - DONE: done=1 for exactly one cycle and busy=0 in that same cycle. The next state is IDLE.
- busy: high in SEND and RECV only.
- start handling: ignored unless the state is IDLE. start arriving in the DONE cycle is ignored.
- res_valid while not in RECV: ignored, res_ready=0, nothing is written.
- wr_en while busy: ignored, so x is protected during a run. wr_en in IDLE or DONE writes normally.
- Simultaneous wr_en and start in IDLE: the write to x[wr_addr] completes before SEND reads it, so the run uses the new value.
- Counters: saturate/clear at N-1 and M-1. No wrap-around beyond a single run.
- rd_data: rbuf[rd_addr] registered every cycle, valid in all states. A read in the same cycle as a write to the same address returns the old value.
- Reset mid-operation: immediate return to IDLE. drv_valid and res_ready drop asynchronously. A partial rbuf is left as-is.

Optional Feature:
- Macro: FC_STREAM_DRIVER_CYCLE_CNT_EN.
- When defined:
  - Adds output port cycle_cnt, 32 bits.
  - It clears on the accepted start, increments every cycle while busy, and holds its value after done until the next start.
  - It resets to 0.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package fc_stream_pkg:
  - state enum typedef (IDLE/SEND/RECV/DONE, 2-bit).
  - default WIDTH constant.
- One natural sub-module: fc_stream_regbuf, a parameterized register-array buffer with synchronous write and registered read. It is instantiated twice, for x (N) and results (M).

Test Plan:
- Basic run (N=4, M=8): write x={1,2,3,4}, pulse start, drv_ready=1, then return res_data 10..17 on single-cycle res_valid beats.
  - Expect drv_data 1,2,3,4 on 4 consecutive cycles.
  - Expect a done pulse 1 cycle after the 8th beat, and rd_addr k returns 10+k.
- Input backpressure: drv_ready toggles 1,0,0,1,...
  - Expect drv_data to hold during stalls and exactly 4 beats in the order 1,2,3,4.
- Protection: wr_en to x[0]=99 during SEND, plus a second start during RECV.
  - Expect both ignored and drv_data[0] unchanged.
  - A subsequent run sends the original x.
- Stray result: res_valid=1, res_data=55 during SEND.
  - Expect res_ready=0 and rbuf[0] not written.
- Reset mid-RECV after 3 results:
  - Expect busy=0 and drv_valid=res_ready=0 immediately; next start reruns cleanly.
- Back-to-back runs, with wr_en+start in the same IDLE cycle setting x[0]=-5.
  - Expect first drv_data=-5.
  - With the macro defined, cycle_cnt equals the busy duration.

Source files
------------

// File: rtl/fc_stream_pkg.sv
// Shared types for the FC accelerator stream driver.
package fc_stream_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, RECV = 2'd2, DONE = 2'd3} state_e;
  localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/fc_stream_regbuf.sv
// Register-array buffer: synchronous write, registered read (1-cycle latency).
// WR_FIRST selects whether a same-address read in the write cycle sees the new word.
module fc_stream_regbuf
  import fc_stream_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = 4,
  parameter int AW       = $clog2(DEPTH),
  parameter bit WR_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [WIDTH-1:0]            rdata_q, rdata_d;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;

  always_comb begin
    rdata_d = mem_q[raddr];
    if (WR_FIRST && we && (waddr == raddr)) rdata_d = wdata;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;

  assign rdata = rdata_q;
endmodule

// File: rtl/fc_stream_driver.sv
// Streams an N-word x vector into an fc core and collects M results for readback.
// Optional FC_STREAM_DRIVER_CYCLE_CNT_EN adds a 32-bit busy-cycle counter output.
module fc_stream_driver
  import fc_stream_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  N     = 4,
  parameter int  M     = 8,
  localparam int LOGN  = $clog2(N),
  localparam int LOGM  = $clog2(M)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [LOGN-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             drv_valid,
  input  logic             drv_ready,
  output logic [WIDTH-1:0] drv_data,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] res_data,
  input  logic [LOGM-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data
`ifdef FC_STREAM_DRIVER_CYCLE_CNT_EN
  ,output logic [31:0]     cycle_cnt
`endif
);
  state_e          state_q, state_d;
  logic [LOGN-1:0] snd_cnt_q, snd_cnt_d;
  logic [LOGM-1:0] rcv_cnt_q, rcv_cnt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            drv_valid_q, drv_valid_d, res_ready_q, res_ready_d;
  logic            start_acc, snd_beat, rcv_beat;

  assign start_acc = start && (state_q == IDLE);
  assign snd_beat  = drv_valid_q && drv_ready;
  assign rcv_beat  = res_ready_q && res_valid;

  always_comb begin
    state_d   = state_q;
    snd_cnt_d = snd_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    unique case (state_q)
      IDLE: if (start_acc) begin
        state_d   = SEND;
        snd_cnt_d = '0;
        rcv_cnt_d = '0;
      end
      SEND: if (snd_beat) begin
        if (snd_cnt_q == LOGN'(N-1)) state_d = RECV;
        else                         snd_cnt_d = snd_cnt_q + LOGN'(1);
      end
      RECV: if (rcv_beat) begin
        if (rcv_cnt_q == LOGM'(M-1)) state_d = DONE;
        else                         rcv_cnt_d = rcv_cnt_q + LOGM'(1);
      end
      DONE: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    busy_d      = (state_d == SEND) || (state_d == RECV);
    done_d      = (state_d == DONE);
    drv_valid_d = (state_d == SEND);
    res_ready_d = (state_d == RECV);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      snd_cnt_q   <= '0;
      rcv_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drv_valid_q <= 1'b0;
      res_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      snd_cnt_q   <= snd_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      drv_valid_q <= drv_valid_d;
      res_ready_q <= res_ready_d;
    end

  // x is read at the next send index; write-first so a write alongside start is seen.
  fc_stream_regbuf #(.WIDTH(WIDTH), .DEPTH(N), .AW(LOGN), .WR_FIRST(1'b1)) u_xbuf (
    .clk(clk), .reset_n(reset_n),
    .we(wr_en && !busy_q), .waddr(wr_addr), .wdata(wr_data),
    .raddr(snd_cnt_d), .rdata(drv_data)
  );

  fc_stream_regbuf #(.WIDTH(WIDTH), .DEPTH(M), .AW(LOGM), .WR_FIRST(1'b0)) u_rbuf (
    .clk(clk), .reset_n(reset_n),
    .we(rcv_beat), .waddr(rcv_cnt_q), .wdata(res_data),
    .raddr(rd_addr), .rdata(rd_data)
  );

`ifdef FC_STREAM_DRIVER_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (start_acc)   cycle_cnt_d = '0;
    else if (busy_q) cycle_cnt_d = cycle_cnt_q + 32'd1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cycle_cnt_q <= '0;
    else          cycle_cnt_q <= cycle_cnt_d;
  assign cycle_cnt = cycle_cnt_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign drv_valid = drv_valid_q;
  assign res_ready = res_ready_q;
endmodule

// File: tb/tb_fc_stream_driver.sv
// Self-checking bench for fc_stream_driver: table-driven basic run, corner sequences, random runs.
module tb_fc_stream_driver;
  localparam int WIDTH = 16, N = 4, M = 8, LOGN = 2, LOGM = 3;

  logic             clk = 1'b0, reset_n = 1'b0;
  logic             wr_en = 1'b0, start = 1'b0, drv_ready = 1'b0, res_valid = 1'b0;
  logic [LOGN-1:0]  wr_addr = '0;
  logic [LOGM-1:0]  rd_addr = '0;
  logic [WIDTH-1:0] wr_data = '0, res_data = '0;
  logic             busy, done, drv_valid, res_ready;
  logic [WIDTH-1:0] drv_data, rd_data;
`ifdef FC_STREAM_DRIVER_CYCLE_CNT_EN
  logic [31:0]      cycle_cnt;
`endif

  always #5 clk = ~clk;

  fc_stream_driver #(.WIDTH(WIDTH), .N(N), .M(M)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .drv_valid(drv_valid), .drv_ready(drv_ready),
    .drv_data(drv_data), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef FC_STREAM_DRIVER_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  // Reference state: what x holds and what each result slot should hold.
  logic [WIDTH-1:0] xm [N];
  logic [WIDTH-1:0] rm [M];
  logic [WIDTH-1:0] rv [M];
  int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0;

  typedef struct {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] exp_rd;
  } vec_t;
  vec_t tbl [M];

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic write_x(input int a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = LOGN'(a); wr_data = d;
    tick();
    wr_en = 1'b0; xm[a] = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0; t0 = cyc;
    chk("start_busy", busy, 1);
  endtask

  // mode 0: ready always, 1: ready 1,0,0 repeating, 2: random ready
  task automatic send_phase(input int mode, input bit protect, input bit stray);
    int beats = 0, cycles = 0;
    chk("send_valid_rise", drv_valid, 1);
    while (drv_valid && cycles < 200) begin
      case (mode)
        0:       drv_ready = 1'b1;
        1:       drv_ready = (cycles % 3 == 0);
        default: drv_ready = 1'($urandom_range(0, 1));
      endcase
      if (protect && cycles == 0) begin wr_en = 1'b1; wr_addr = '0; wr_data = 16'd99; end
      if (stray) begin res_valid = 1'b1; res_data = 16'd55; end
      if (beats < N) chk("drv_data", drv_data, xm[beats]);
      if (stray) chk("stray_res_ready", res_ready, 0);
      if (drv_ready) beats++;
      tick();
      cycles++;
      wr_en = 1'b0; res_valid = 1'b0; drv_ready = 1'b0;
    end
    chk("send_beats", beats, N);
    if (mode == 0) chk("send_cycles", cycles, N);
    chk("recv_busy", busy, 1);
    chk("recv_res_ready", res_ready, 1);
  endtask

  // Delivers rv[0..nb-1]; gaps adds random idle cycles between beats.
  task automatic recv_phase(input bit gaps, input bit start_mid, input int nb, input bit start_in_done);
    for (int k = 0; k < nb; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      res_valid = 1'b1; res_data = rv[k]; rm[k] = rv[k];
      if (start_mid && k == 2) start = 1'b1;
      chk("res_ready", res_ready, 1);
      tick();
      res_valid = 1'b0; start = 1'b0;
      if (k < M-1) chk("done_early", done, 0);
    end
    if (nb == M) begin
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
`ifdef FC_STREAM_DRIVER_CYCLE_CNT_EN
      chk("cycle_cnt", cycle_cnt, cyc - t0);
`endif
      if (start_in_done) start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_clear", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_valid", drv_valid, 0);
    end
  endtask

  task automatic readback();
    for (int k = 0; k < M; k++) begin
      rd_addr = LOGM'(k);
      tick();
      chk("rd_data", rd_data, rm[k]);
    end
  endtask

  task automatic fill_rv_random();
    for (int k = 0; k < M; k++) rv[k] = WIDTH'($urandom);
  endtask

  initial begin
    for (int k = 0; k < M; k++) begin
      tbl[k].x      = WIDTH'(k + 1);
      tbl[k].res    = WIDTH'(10 + k);
      tbl[k].exp_rd = WIDTH'(10 + k);
    end

    tick(); tick();
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_valid", drv_valid, 0); chk("rst_ready", res_ready, 0);
    chk("rst_drv_data", drv_data, 0); chk("rst_rd_data", rd_data, 0);
    reset_n = 1'b1;
    tick();

    // Basic run from the table.
    for (int k = 0; k < N; k++) write_x(k, tbl[k].x);
    for (int k = 0; k < M; k++) rv[k] = tbl[k].res;
    do_start();
    send_phase(0, 1'b0, 1'b0);
    recv_phase(1'b0, 1'b0, M, 1'b0);
    for (int k = 0; k < M; k++) begin
      rd_addr = LOGM'(k);
      tick();
      chk("tbl_rd_data", rd_data, tbl[k].exp_rd);
    end

    // Input backpressure.
    fill_rv_random();
    do_start();
    send_phase(1, 1'b0, 1'b0);
    recv_phase(1'b1, 1'b0, M, 1'b0);
    readback();

    // Protection against x writes and a second start, plus a stray result in SEND.
    fill_rv_random();
    do_start();
    send_phase(2, 1'b1, 1'b1);
    rd_addr = '0;
    tick();
    chk("stray_rbuf0", rd_data, rm[0]);
    recv_phase(1'b1, 1'b1, M, 1'b0);
    readback();
    fill_rv_random();
    do_start();
    send_phase(0, 1'b0, 1'b0);
    recv_phase(1'b0, 1'b0, M, 1'b0);

    // Reset mid-RECV after 3 results.
    fill_rv_random();
    do_start();
    send_phase(2, 1'b0, 1'b0);
    recv_phase(1'b1, 1'b0, 3, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", drv_valid, 0);
    chk("mid_rst_ready", res_ready, 0);
    tick();
    reset_n = 1'b1;
    readback();
    fill_rv_random();
    do_start();
    send_phase(0, 1'b0, 1'b0);
    recv_phase(1'b0, 1'b0, M, 1'b1);

    // Back-to-back: write+start in the same IDLE cycle.
    fill_rv_random();
    wr_en = 1'b1; wr_addr = '0; wr_data = WIDTH'(-5); start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0; xm[0] = WIDTH'(-5); t0 = cyc;
    chk("b2b_first_data", drv_data, 16'hFFFB);
    send_phase(0, 1'b0, 1'b0);
    recv_phase(1'b0, 1'b0, M, 1'b0);
    fill_rv_random();
    do_start();
    send_phase(2, 1'b0, 1'b0);
    recv_phase(1'b1, 1'b0, M, 1'b0);
    readback();

    // Random runs.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < N; k++) write_x(k, WIDTH'($urandom));
      fill_rv_random();
      do_start();
      send_phase(2, 1'b0, 1'b0);
      recv_phase(1'b1, 1'b0, M, 1'b0);
      readback();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
